// File: rtl/unstacker.sv
// Unstacker: splits 128-bit frame-buffer read chunks into a 1-pixel/cycle AXI-Stream, LSB byte first.
// Optional build macro UNSTACKER_TKEEP_EN adds a per-byte chunk_tkeep mask that skips unkept bytes.
module unstacker #(
  parameter int PIXEL_W      = 8,
  parameter int CHUNK_PIXELS = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              chunk_tvalid,
  output logic                              chunk_tready,
  input  logic [PIXEL_W*CHUNK_PIXELS-1:0]   chunk_tdata,
  input  logic                              chunk_tlast,
`ifdef UNSTACKER_TKEEP_EN
  input  logic [CHUNK_PIXELS-1:0]           chunk_tkeep,
`endif
  output logic                              pixel_tvalid,
  input  logic                              pixel_tready,
  output logic [PIXEL_W-1:0]                pixel_tdata,
  output logic                              pixel_tlast
);

  localparam int CHUNK_W = PIXEL_W * CHUNK_PIXELS;
  localparam int IDX_W   = $clog2(CHUNK_PIXELS);

  logic [CHUNK_W-1:0] act_data, pend_data;
  logic               act_last, pend_last;
  logic               act_valid, pend_valid;
  logic [IDX_W-1:0]   idx;

  logic               accept, xfer, last_pix, act_free, pend_valid_next;
  logic               in_ok;
  logic [IDX_W-1:0]   idx_step, idx_first_in, idx_first_pend;

`ifdef UNSTACKER_TKEEP_EN
  logic [CHUNK_PIXELS-1:0] act_keep, pend_keep, keep_above;

  function automatic logic [IDX_W-1:0] low_bit(input logic [CHUNK_PIXELS-1:0] m);
    low_bit = '0;
    for (int i = CHUNK_PIXELS - 1; i >= 0; i--)
      if (m[i]) low_bit = IDX_W'(i);
  endfunction

  // Kept bytes strictly above the current index decide both the next index and end-of-chunk.
  always_comb begin
    keep_above     = act_keep & ({{(CHUNK_PIXELS-1){1'b1}}, 1'b0} << idx);
    last_pix       = ~|keep_above;
    idx_step       = low_bit(keep_above);
    idx_first_in   = low_bit(chunk_tkeep);
    idx_first_pend = low_bit(pend_keep);
    in_ok          = |chunk_tkeep;
  end
`else
  always_comb begin
    last_pix       = (idx == IDX_W'(CHUNK_PIXELS - 1));
    idx_step       = idx + IDX_W'(1);
    idx_first_in   = '0;
    idx_first_pend = '0;
    in_ok          = 1'b1;
  end
`endif

  // chunk_tready mirrors an empty pending slot, so an accept always finds pending free.
  always_comb begin
    accept          = chunk_tvalid && chunk_tready;
    xfer            = act_valid && pixel_tready;
    act_free        = !act_valid || (xfer && last_pix);
    pend_valid_next = act_free ? 1'b0 : (pend_valid || (accept && in_ok));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      chunk_tready <= 1'b0;
      act_data     <= '0;
      act_last     <= 1'b0;
      act_valid    <= 1'b0;
      pend_data    <= '0;
      pend_last    <= 1'b0;
      pend_valid   <= 1'b0;
      idx          <= '0;
`ifdef UNSTACKER_TKEEP_EN
      act_keep     <= '0;
      pend_keep    <= '0;
`endif
    end else begin
      chunk_tready <= !pend_valid_next;
      pend_valid   <= pend_valid_next;
      if (act_free) begin
        if (pend_valid) begin
          act_data  <= pend_data;
          act_last  <= pend_last;
          act_valid <= 1'b1;
          idx       <= idx_first_pend;
`ifdef UNSTACKER_TKEEP_EN
          act_keep  <= pend_keep;
`endif
        end else if (accept && in_ok) begin
          act_data  <= chunk_tdata;
          act_last  <= chunk_tlast;
          act_valid <= 1'b1;
          idx       <= idx_first_in;
`ifdef UNSTACKER_TKEEP_EN
          act_keep  <= chunk_tkeep;
`endif
        end else begin
          act_valid <= 1'b0;
          idx       <= '0;
        end
      end else begin
        if (xfer) idx <= idx_step;
        if (accept && in_ok) begin
          pend_data <= chunk_tdata;
          pend_last <= chunk_tlast;
`ifdef UNSTACKER_TKEEP_EN
          pend_keep <= chunk_tkeep;
`endif
        end
      end
    end
  end

  always_comb begin
    pixel_tvalid = act_valid;
    pixel_tdata  = act_data[idx*PIXEL_W +: PIXEL_W];
    pixel_tlast  = act_valid && act_last && last_pix;
  end

endmodule

// File: tb/tb_unstacker.sv
// Self-checking bench for unstacker: directed scenarios plus random traffic against a pixel-queue model.
module tb_unstacker;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         chunk_tvalid;
  logic         chunk_tready;
  logic [127:0] chunk_tdata;
  logic         chunk_tlast;
  logic         pixel_tvalid;
  logic         pixel_tready;
  logic [7:0]   pixel_tdata;
  logic         pixel_tlast;

  int total = 0;
  int bad   = 0;

  // Model: every pixel still owed downstream, as {last, data}, in emission order.
  logic [8:0] q[$];
  logic       exp_tready;
  logic       exp_valid;
  logic       last_accept;

  always #5 clk_in = ~clk_in;

  unstacker dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .chunk_tvalid (chunk_tvalid),
    .chunk_tready (chunk_tready),
    .chunk_tdata  (chunk_tdata),
    .chunk_tlast  (chunk_tlast),
`ifdef UNSTACKER_TKEEP_EN
    .chunk_tkeep  (16'hFFFF),
`endif
    .pixel_tvalid (pixel_tvalid),
    .pixel_tready (pixel_tready),
    .pixel_tdata  (pixel_tdata),
    .pixel_tlast  (pixel_tlast)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // One clock cycle: drive at posedge+1, check and advance the model at negedge.
  task automatic applyStimulus(input logic cv, input logic [127:0] cd, input logic cl, input logic pr);
    logic acc, xf;
    chunk_tvalid = cv;
    chunk_tdata  = cd;
    chunk_tlast  = cl;
    pixel_tready = pr;
    @(negedge clk_in);
    checkOutput("pixel_tvalid", pixel_tvalid, exp_valid);
    checkOutput("chunk_tready", chunk_tready, exp_tready);
    if (exp_valid) begin
      checkOutput("pixel_tdata", pixel_tdata, q[0][7:0]);
      checkOutput("pixel_tlast", pixel_tlast, q[0][8]);
    end
    acc = cv && exp_tready;
    xf  = pr && exp_valid;
    if (xf) void'(q.pop_front());
    if (acc)
      for (int b = 0; b < 16; b++) q.push_back({(b == 15) && cl, cd[b*8 +: 8]});
    last_accept = acc;
    // More than one chunk's worth outstanding means both slots are occupied.
    exp_tready = (q.size() <= 16);
    exp_valid  = (q.size() != 0);
    @(posedge clk_in);
    #1;
  endtask

  task automatic sendChunk(input logic [127:0] cd, input logic cl, input logic pr);
    int n = 0;
    do begin
      applyStimulus(1'b1, cd, cl, pr);
      n++;
    end while (!last_accept && n < 200);
    if (!last_accept) checkOutput("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n, input logic pr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 128'h0, 1'b0, pr);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tvalid"}, pixel_tvalid, 1'b0);
    checkOutput({tag, "_tdata"},  pixel_tdata,  8'h00);
    checkOutput({tag, "_tlast"},  pixel_tlast,  1'b0);
    checkOutput({tag, "_tready"}, chunk_tready, 1'b0);
  endtask

  task automatic applyReset();
    rst_in       = 1'b0;
    chunk_tvalid = 1'b0;
    chunk_tdata  = '0;
    chunk_tlast  = 1'b0;
    pixel_tready = 1'b0;
    #1;
    checkResetOutputs("reset_async");
    q.delete();
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    checkResetOutputs("reset_held");
    rst_in     = 1'b1;
    exp_tready = 1'b0;
    exp_valid  = 1'b0;
  endtask

  function automatic logic [127:0] randChunk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] pend_data;
    logic         pend_last;
    logic         offering;
    logic         cv, pr;

    rst_in       = 1'b0;
    chunk_tvalid = 1'b0;
    chunk_tdata  = '0;
    chunk_tlast  = 1'b0;
    pixel_tready = 1'b0;
    exp_tready   = 1'b0;
    exp_valid    = 1'b0;
    last_accept  = 1'b0;
    #12;
    applyReset();

    // Ascending byte pattern, no tlast, then drain to idle.
    sendChunk(128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 1'b1);
    idle(20, 1'b1);

    // Three back-to-back chunks, last one carries tlast.
    sendChunk(randChunk(), 1'b0, 1'b1);
    sendChunk(randChunk(), 1'b0, 1'b1);
    sendChunk(128'h0F0E0D0C0B0A09080706050403020100, 1'b1, 1'b1);
    idle(40, 1'b1);

    // Stall at byte 7: second chunk lands in pending, third waits for the drain.
    sendChunk(randChunk(), 1'b0, 1'b1);
    idle(7, 1'b1);
    sendChunk(randChunk(), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b1, 1'b0);
    sendChunk(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b1, 1'b1);
    idle(40, 1'b1);

    // Reset with active at byte 5 and pending full; nothing may leak out afterwards.
    sendChunk(randChunk(), 1'b0, 1'b1);
    sendChunk(randChunk(), 1'b1, 1'b1);
    idle(4, 1'b1);
    applyReset();
    idle(20, 1'b1);

    // Random traffic with a source that holds its chunk until accepted.
    offering  = 1'b0;
    pend_data = '0;
    pend_last = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!offering) begin
        pend_data = randChunk();
        pend_last = ($urandom_range(0, 3) == 0);
        offering  = ($urandom_range(0, 9) < 6);
      end
      cv = offering;
      pr = ($urandom_range(0, 3) != 0);
      applyStimulus(cv, pend_data, pend_last, pr);
      if (last_accept) offering = 1'b0;
    end
    idle(60, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
